// File: rtl/lfsr_pkg.sv
// Shared definitions for the Fibonacci LFSR generator/checker pair:
// checker state encoding and the one-step LFSR advance function.
package lfsr_pkg;

   localparam int LFSR_MAX_W = 64;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_CHECK  = 2'd1,
      ST_LOCKED = 2'd2
   } lfsr_state_e;

   // next(w) = {^(w & poly), w[width-1:1]}; operands are zero-extended to LFSR_MAX_W.
   function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] word,
                                                       input logic [LFSR_MAX_W-1:0] poly,
                                                       input int                    width);
      logic [LFSR_MAX_W-1:0] res;
      logic                  fb;
      fb  = ^(word & poly);
      res = word >> 1;
      for (int i = 0; i < LFSR_MAX_W; i++) begin
         if (i == width - 1) res[i] = fb;
      end
      return res;
   endfunction

endpackage

// File: rtl/fibonacci_lfsr_checker_popcount.sv
// Population count used for bit-error accounting; only built when
// FIBONACCI_LFSR_CHECKER_BITERR_EN is defined.
`ifdef FIBONACCI_LFSR_CHECKER_BITERR_EN
module popcount #(
   parameter int W    = 8,
   parameter int CW   = $clog2(W + 1)
) (
   input  logic [W-1:0]  din,
   output logic [CW-1:0] cnt
);

   always_comb begin
      cnt = '0;
      for (int i = 0; i < W; i++) begin
         cnt = cnt + CW'(din[i]);
      end
   end

endmodule
`endif

// File: rtl/fibonacci_lfsr_checker.sv
// Receive-side PRBS checker: hunts for a valid LFSR word, confirms it, then freewheels
// and counts mismatches. Define FIBONACCI_LFSR_CHECKER_BITERR_EN to count bit errors.
module fibonacci_lfsr_checker
   import lfsr_pkg::*;
#(
   parameter int                  DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] POLY     = 8'b00001001,
   parameter int                  LOCK_COUNT = 4,
   parameter int                  LOSS_COUNT = 4,
   parameter int                  ERR_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_cnt,
   input  logic                  din_valid,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  locked,
   output logic                  word_err,
   output logic [ERR_WIDTH-1:0]  err_cnt
);

   localparam int MW    = $clog2(LOCK_COUNT + 1);
   localparam int SW    = $clog2(LOSS_COUNT + 1);
   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam int SUM_W = ((ERR_WIDTH > CNT_W) ? ERR_WIDTH : CNT_W) + 1;

   lfsr_state_e           state_q, state_d;
   logic [DATA_WIDTH-1:0] exp_q, exp_d;
   logic [MW-1:0]         match_cnt_q, match_cnt_d;
   logic [SW-1:0]         miss_cnt_q, miss_cnt_d;
   logic                  word_err_q, word_err_d;
   logic [ERR_WIDTH-1:0]  err_cnt_q, err_cnt_d;

   logic [DATA_WIDTH-1:0] nxt_din, nxt_exp;
   logic [MW-1:0]         match_inc;
   logic [SW-1:0]         miss_inc;
   logic [CNT_W-1:0]      incr;
   logic [SUM_W-1:0]      err_sum;
   logic [ERR_WIDTH-1:0]  err_sat;

   assign nxt_din   = DATA_WIDTH'(lfsr_next(LFSR_MAX_W'(din), LFSR_MAX_W'(POLY), DATA_WIDTH));
   assign nxt_exp   = DATA_WIDTH'(lfsr_next(LFSR_MAX_W'(exp_q), LFSR_MAX_W'(POLY), DATA_WIDTH));
   assign match_inc = match_cnt_q + MW'(1);
   assign miss_inc  = miss_cnt_q + SW'(1);

`ifdef FIBONACCI_LFSR_CHECKER_BITERR_EN
   popcount #(.W(DATA_WIDTH), .CW(CNT_W)) u_popcount (
      .din (din ^ exp_q),
      .cnt (incr)
   );
`else
   assign incr = CNT_W'(1);
`endif

   // Saturating add: one extra bit catches overflow, which pins the count at all-ones.
   assign err_sum = SUM_W'(err_cnt_q) + SUM_W'(incr);
   assign err_sat = (err_sum > SUM_W'({ERR_WIDTH{1'b1}})) ? {ERR_WIDTH{1'b1}} : ERR_WIDTH'(err_sum);

   always_comb begin
      state_d     = state_q;
      exp_d       = exp_q;
      match_cnt_d = match_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      word_err_d  = 1'b0;
      err_cnt_d   = err_cnt_q;
      if (din_valid) begin
         unique case (state_q)
            ST_HUNT: begin
               if (din != '0) begin
                  exp_d       = nxt_din;
                  match_cnt_d = '0;
                  state_d     = ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (din == exp_q) begin
                  exp_d       = nxt_din;
                  match_cnt_d = match_inc;
                  if (match_inc == MW'(LOCK_COUNT)) begin
                     state_d     = ST_LOCKED;
                     match_cnt_d = '0;
                     miss_cnt_d  = '0;
                  end
               end else if (din != '0) begin
                  exp_d       = nxt_din;
                  match_cnt_d = '0;
               end else begin
                  match_cnt_d = '0;
                  state_d     = ST_HUNT;
               end
            end
            ST_LOCKED: begin
               // Freewheel: din never reseeds exp here, so one bad word costs one error.
               exp_d = nxt_exp;
               if (din == exp_q) begin
                  miss_cnt_d = '0;
               end else begin
                  word_err_d = 1'b1;
                  err_cnt_d  = err_sat;
                  if (miss_inc == SW'(LOSS_COUNT)) begin
                     miss_cnt_d = '0;
                     state_d    = ST_HUNT;
                  end else begin
                     miss_cnt_d = miss_inc;
                  end
               end
            end
            default: state_d = ST_HUNT;
         endcase
      end
      if (clr_cnt) err_cnt_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_HUNT;
         exp_q       <= '0;
         match_cnt_q <= '0;
         miss_cnt_q  <= '0;
         word_err_q  <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         exp_q       <= exp_d;
         match_cnt_q <= match_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         word_err_q  <= word_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign locked   = (state_q == ST_LOCKED);
   assign word_err = word_err_q;
   assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_fibonacci_lfsr_checker.sv
// Directed bench for fibonacci_lfsr_checker (DATA_WIDTH=8, POLY=8'h09, ERR_WIDTH=4).
// Valid/ready note: din is consumed on every clock where din_valid=1; there is no backpressure.
module tb_fibonacci_lfsr_checker;

   logic       clk;
   logic       rst;
   logic       clr_cnt;
   logic       din_valid;
   logic [7:0] din;
   logic       locked;
   logic       word_err;
   logic [3:0] err_cnt;

   int total = 0;
   int bad   = 0;
   logic [7:0] g;

`ifdef FIBONACCI_LFSR_CHECKER_BITERR_EN
   localparam logic [3:0] FF_INC = 4'd8;
`else
   localparam logic [3:0] FF_INC = 4'd1;
`endif

   typedef struct {
      logic       valid;
      logic       use_gen;
      logic [7:0] data;
      logic       clr;
      logic       exp_locked;
      logic       exp_werr;
      logic [3:0] exp_err;
   } vec_t;

   vec_t vecs[$];

   fibonacci_lfsr_checker #(
      .DATA_WIDTH (8),
      .POLY       (8'h09),
      .LOCK_COUNT (4),
      .LOSS_COUNT (4),
      .ERR_WIDTH  (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clr_cnt   (clr_cnt),
      .din_valid (din_valid),
      .din       (din),
      .locked    (locked),
      .word_err  (word_err),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] gen_next(input logic [7:0] w);
      return {^(w & 8'h09), w[7:1]};
   endfunction

   task automatic check(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // One clock: inputs set, edge, then outputs sampled 2ns after the edge.
   task automatic step(input logic v, input logic [7:0] d, input logic c);
      din_valid = v;
      din       = d;
      clr_cnt   = c;
      @(posedge clk);
      #2;
   endtask

   // Send the current generator word xor mask; the generator advances on valid steps.
   task automatic send_gen(input logic v, input logic [7:0] mask, input logic c);
      step(v, g ^ mask, c);
      if (v) g = gen_next(g);
   endtask

   task automatic add(input logic v, input logic ug, input logic [7:0] d, input logic c,
                      input logic el, input logic ew, input logic [3:0] ee, input int n);
      vec_t x;
      x.valid = v; x.use_gen = ug; x.data = d; x.clr = c;
      x.exp_locked = el; x.exp_werr = ew; x.exp_err = ee;
      for (int i = 0; i < n; i++) vecs.push_back(x);
   endtask

   task automatic expect_out(input string tag, input logic el, input logic ew, input logic [3:0] ee);
      check({tag, ".locked"}, int'(locked), int'(el));
      check({tag, ".word_err"}, int'(word_err), int'(ew));
      check({tag, ".err_cnt"}, int'(err_cnt), int'(ee));
   endtask

   initial begin
      // valid use_gen data clr | locked werr err | repeat
      add(1, 0, 8'h00, 0, 0, 0, 4'd0, 3);   // lockup word ignored in HUNT
      add(1, 1, 8'h00, 0, 0, 0, 4'd0, 3);   // seed + 2 matches
      add(1, 1, 8'h01, 0, 0, 0, 4'd0, 1);   // CHECK mismatch: resync, no error counted
      add(1, 1, 8'h00, 0, 0, 0, 4'd0, 4);   // resync then 3 matches
      add(1, 1, 8'h00, 0, 1, 0, 4'd0, 1);   // 4th match -> LOCKED
      add(0, 0, 8'hAA, 0, 1, 0, 4'd0, 1);   // gap with garbage on din
      add(1, 1, 8'h00, 0, 1, 0, 4'd0, 3);
      add(1, 1, 8'h01, 0, 1, 1, 4'd1, 1);   // single bit0 corruption
      add(1, 1, 8'h00, 0, 1, 0, 4'd1, 2);
      add(1, 1, 8'h01, 0, 1, 1, 4'd2, 1);   // 4 consecutive bad words
      add(1, 1, 8'h01, 0, 1, 1, 4'd3, 1);
      add(1, 1, 8'h01, 0, 1, 1, 4'd4, 1);
      add(1, 1, 8'h01, 0, 0, 1, 4'd5, 1);   // lock lost, err_cnt held
      add(1, 1, 8'h00, 0, 0, 0, 4'd5, 4);
      add(1, 1, 8'h00, 0, 1, 0, 4'd5, 1);   // relock on 5th clean word
      for (int i = 0; i < 3; i++) begin
         add(1, 1, 8'h00, 0, 1, 0, 4'd5, 1);
         add(0, 0, 8'h00, 0, 1, 0, 4'd5, 1);
      end
      add(1, 1, 8'h01, 1, 1, 1, 4'd0, 1);   // clear beats coincident error
      add(1, 1, 8'h00, 0, 1, 0, 4'd0, 1);
      add(1, 1, 8'hFF, 0, 1, 1, FF_INC, 1); // all bits wrong
      add(1, 1, 8'h00, 0, 1, 0, FF_INC, 1);
      add(1, 1, 8'h00, 1, 1, 0, 4'd0, 1);

      rst = 1'b1; clr_cnt = 1'b0; din_valid = 1'b0; din = 8'h00; g = 8'h01;
      repeat (3) @(posedge clk);
      #2;
      expect_out("reset", 1'b0, 1'b0, 4'd0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         if (vecs[i].use_gen) send_gen(vecs[i].valid, vecs[i].data, vecs[i].clr);
         else                 step(vecs[i].valid, vecs[i].data, vecs[i].clr);
         expect_out($sformatf("vec%0d", i), vecs[i].exp_locked, vecs[i].exp_werr, vecs[i].exp_err);
      end

      // Saturation: alternate bad/good words so lock is held while errors pile up.
      for (int k = 1; k <= 20; k++) begin
         send_gen(1'b1, 8'h01, 1'b0);
         expect_out($sformatf("sat_bad%0d", k), 1'b1, 1'b1, (k > 15) ? 4'hF : 4'(k));
         send_gen(1'b1, 8'h00, 1'b0);
         check($sformatf("sat_good%0d.err_cnt", k), int'(err_cnt), (k > 15) ? 15 : k);
      end

      send_gen(1'b1, 8'h00, 1'b1);
      expect_out("clr_after_sat", 1'b1, 1'b0, 4'd0);

      for (int k = 0; k < 1000; k++) begin
         send_gen(1'b1, 8'h00, 1'b0);
         check("clean_run.err_cnt", int'(err_cnt), 0);
         check("clean_run.word_err", int'(word_err), 0);
      end
      check("clean_run.locked", int'(locked), 1);

      // Async reset between edges: outputs clear without any clock edge.
      send_gen(1'b1, 8'h01, 1'b0);
      expect_out("pre_rst", 1'b1, 1'b1, 4'd1);
      #2;
      rst = 1'b1;
      #1;
      expect_out("async_rst", 1'b0, 1'b0, 4'd0);
      #1;
      rst = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         send_gen(1'b1, 8'h00, 1'b0);
         expect_out($sformatf("relock%0d", k), (k == 5), 1'b0, 4'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
